// File: rtl/seq_checker.sv
// Sequence checker: locks onto the repeating counter pattern 2,1,2,3,2,4,2,5 and flags deviations.
// Latency: one cycle; every output is registered and reflects the sample taken on the previous edge.
// Backpressure: none; samples are taken whenever in_valid=1 and dropped silently otherwise.
//
// Ports:
//   clk      - sole clock, rising edge
//   rst      - synchronous active-high reset
//   in_valid - qualifies count
//   count    - 3-bit value from the upstream sequence counter
//   err_clr  - synchronous clear of err_cnt (wins over a simultaneous increment)
//   locked   - high while in LOCKED
//   err      - one-cycle pulse per mismatching sample while LOCKED
//   err_cnt  - saturating count of err pulses
//   phase    - sequence index of the last accepted sample
module seq_checker #(
    parameter int unsigned LOCK_CNT = 8,  // 2..15
    parameter int unsigned MISS_MAX = 3   // 1..7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [2:0] count,
    input  logic       err_clr,
    output logic       locked,
    output logic       err,
    output logic [7:0] err_cnt,
    output logic [2:0] phase
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_CNT_L = 4'(LOCK_CNT);
    localparam logic [2:0] MISS_MAX_L = 3'(MISS_MAX);

    // Reference pattern: even indices are all 2, odd indices carry 1,3,4,5.
    function automatic logic [2:0] seq_at(input logic [2:0] idx);
        logic [2:0] v;
        case (idx)
            3'd1:    v = 3'd1;
            3'd3:    v = 3'd3;
            3'd5:    v = 3'd4;
            3'd7:    v = 3'd5;
            default: v = 3'd2;
        endcase
        return v;
    endfunction

    state_t     state_q, state_d;
    logic [2:0] phase_q, phase_d;
    logic [3:0] match_cnt_q, match_cnt_d;
    logic [2:0] miss_cnt_q, miss_cnt_d;
    logic       err_q, err_d;
    logic [7:0] err_cnt_q, err_cnt_d;
    logic       locked_q, locked_d;

    logic [2:0] phase_next;
    logic       is_match;

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        err_d       = 1'b0;
        err_cnt_d   = err_cnt_q;

        phase_next  = phase_q + 3'd1;
        is_match    = (count == seq_at(phase_next));

        if (in_valid) begin
            case (state_q)
                HUNT: begin
                    // Only the odd-index values identify phase uniquely; 2 is ambiguous.
                    case (count)
                        3'd1: begin phase_d = 3'd1; state_d = VERIFY; match_cnt_d = 4'd1; end
                        3'd3: begin phase_d = 3'd3; state_d = VERIFY; match_cnt_d = 4'd1; end
                        3'd4: begin phase_d = 3'd5; state_d = VERIFY; match_cnt_d = 4'd1; end
                        3'd5: begin phase_d = 3'd7; state_d = VERIFY; match_cnt_d = 4'd1; end
                        default: ;
                    endcase
                end
                VERIFY: begin
                    if (is_match) begin
                        phase_d     = phase_next;
                        match_cnt_d = match_cnt_q + 4'd1;
                        if (match_cnt_q + 4'd1 == LOCK_CNT_L) begin
                            state_d    = LOCKED;
                            miss_cnt_d = 3'd0;
                        end
                    end else begin
                        // Mismatch is discarded; acquisition restarts on the next sample.
                        state_d     = HUNT;
                        match_cnt_d = 4'd0;
                    end
                end
                LOCKED: begin
                    // Phase flywheels forward on mismatches too, so one corrupt sample
                    // does not disturb alignment.
                    phase_d = phase_next;
                    if (is_match) begin
                        miss_cnt_d = 3'd0;
                    end else begin
                        err_d      = 1'b1;
                        miss_cnt_d = miss_cnt_q + 3'd1;
                        if (err_cnt_q != 8'hFF) begin
                            err_cnt_d = err_cnt_q + 8'd1;
                        end
                        if (miss_cnt_q + 3'd1 == MISS_MAX_L) begin
                            state_d     = HUNT;
                            miss_cnt_d  = 3'd0;
                            match_cnt_d = 4'd0;
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end

        if (err_clr) begin
            err_cnt_d = 8'd0;
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HUNT;
            phase_q     <= 3'd0;
            match_cnt_q <= 4'd0;
            miss_cnt_q  <= 3'd0;
            err_q       <= 1'b0;
            err_cnt_q   <= 8'd0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
            locked_q    <= locked_d;
        end
    end

    assign locked  = locked_q;
    assign err     = err_q;
    assign err_cnt = err_cnt_q;
    assign phase   = phase_q;

endmodule

// File: tb/tb_seq_checker.sv
// Self-checking bench for seq_checker: vector table plus hand-written multi-cycle sequences.
// Latency: each applied vector is checked one edge later, #1 after the rising edge.
// Backpressure: none; expected records queue up as stimulus is driven and are popped on output.
module tb_seq_checker;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [2:0] count;
    logic       err_clr;
    logic       locked;
    logic       err;
    logic [7:0] err_cnt;
    logic [2:0] phase;

    int checks   = 0;
    int failures = 0;

    seq_checker #(.LOCK_CNT(8), .MISS_MAX(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .count    (count),
        .err_clr  (err_clr),
        .locked   (locked),
        .err      (err),
        .err_cnt  (err_cnt),
        .phase    (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic       v;
        logic [2:0] c;
        logic       cl;
        logic       e_locked;
        logic       e_err;
        logic [7:0] e_cnt;
        logic [2:0] e_phase;
    } vec_t;

    typedef struct {
        logic       e_locked;
        logic       e_err;
        logic [7:0] e_cnt;
        logic [2:0] e_phase;
        string      tag;
    } exp_t;

    exp_t       sb_q[$];
    vec_t       tbl[27];
    logic [2:0] seq_ref[8];

    // Drive one cycle of stimulus, queue its expectation, then pop and compare
    // once the registered outputs have settled after the edge.
    task automatic apply(input logic r, input logic v, input logic [2:0] c, input logic cl,
                         input logic el, input logic ee, input logic [7:0] ec,
                         input logic [2:0] ep, input string tag);
        exp_t e;
        exp_t got;
        rst      = r;
        in_valid = v;
        count    = c;
        err_clr  = cl;
        e.e_locked = el;
        e.e_err    = ee;
        e.e_cnt    = ec;
        e.e_phase  = ep;
        e.tag      = tag;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        checks++;
        if (locked !== got.e_locked || err !== got.e_err ||
            err_cnt !== got.e_cnt || phase !== got.e_phase) begin
            failures++;
            $display("FAIL %s: got locked=%0b err=%0b err_cnt=%0d phase=%0d, want locked=%0b err=%0b err_cnt=%0d phase=%0d",
                     got.tag, locked, err, err_cnt, phase,
                     got.e_locked, got.e_err, got.e_cnt, got.e_phase);
        end
    endtask

    // Reset, then feed the clean pattern from index 0 until lock (9th sample).
    task automatic reset_and_lock(input string tag);
        apply(1, 0, 3'd0, 0, 0, 0, 8'd0, 3'd0, {tag, "_rst"});
        for (int k = 0; k < 9; k++) begin
            apply(0, 1, seq_ref[k % 8], 0, (k == 8), 0, 8'd0,
                  (k == 0) ? 3'd0 : 3'(k % 8), {tag, "_acq"});
        end
    endtask

    initial begin
        logic [2:0] p;
        int         n;
        logic [7:0] ecnt;

        seq_ref[0] = 3'd2; seq_ref[1] = 3'd1; seq_ref[2] = 3'd2; seq_ref[3] = 3'd3;
        seq_ref[4] = 3'd2; seq_ref[5] = 3'd4; seq_ref[6] = 3'd2; seq_ref[7] = 3'd5;

        //            rst vld cnt   clr   locked err cnt    phase
        tbl[0]  = '{1'b1, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 8'd0, 3'd0}; // reset state
        tbl[1]  = '{1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 8'd0, 3'd0}; // 2 ambiguous: hunt
        tbl[2]  = '{1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 8'd0, 3'd1}; // acquire
        tbl[3]  = '{1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 8'd0, 3'd2};
        tbl[4]  = '{1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 8'd0, 3'd3};
        tbl[5]  = '{1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 8'd0, 3'd4};
        tbl[6]  = '{1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 8'd0, 3'd5};
        tbl[7]  = '{1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 8'd0, 3'd6};
        tbl[8]  = '{1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 8'd0, 3'd7};
        tbl[9]  = '{1'b0, 1'b1, 3'd2, 1'b0, 1'b1, 1'b0, 8'd0, 3'd0}; // 8th match: lock
        tbl[10] = '{1'b0, 1'b1, 3'd1, 1'b0, 1'b1, 1'b0, 8'd0, 3'd1};
        tbl[11] = '{1'b0, 1'b1, 3'd2, 1'b0, 1'b1, 1'b0, 8'd0, 3'd2};
        tbl[12] = '{1'b0, 1'b1, 3'd3, 1'b0, 1'b1, 1'b0, 8'd0, 3'd3};
        tbl[13] = '{1'b0, 1'b1, 3'd6, 1'b0, 1'b1, 1'b1, 8'd1, 3'd4}; // single corrupt
        tbl[14] = '{1'b0, 1'b1, 3'd4, 1'b0, 1'b1, 1'b0, 8'd1, 3'd5}; // match clears miss
        tbl[15] = '{1'b0, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0, 8'd0, 3'd6}; // err_clr
        tbl[16] = '{1'b0, 1'b1, 3'd7, 1'b0, 1'b1, 1'b1, 8'd1, 3'd7}; // miss 1
        tbl[17] = '{1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b1, 8'd2, 3'd0}; // miss 2
        tbl[18] = '{1'b0, 1'b1, 3'd6, 1'b0, 1'b0, 1'b1, 8'd3, 3'd1}; // miss 3: unlock
        tbl[19] = '{1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 8'd3, 3'd1}; // hunt holds phase
        tbl[20] = '{1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 8'd3, 3'd3}; // acquire on 3
        tbl[21] = '{1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 8'd3, 3'd3}; // verify miss: hunt, no err
        tbl[22] = '{1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 8'd3, 3'd3}; // 2 keeps hunt
        tbl[23] = '{1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 8'd3, 3'd5}; // acquire on 4
        tbl[24] = '{1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 8'd3, 3'd5}; // invalid ignored
        tbl[25] = '{1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 8'd3, 3'd6};
        tbl[26] = '{1'b1, 1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 8'd0, 3'd0}; // reset mid-verify

        rst = 1'b1; in_valid = 1'b0; count = 3'd0; err_clr = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 27; i++) begin
            apply(tbl[i].r, tbl[i].v, tbl[i].c, tbl[i].cl,
                  tbl[i].e_locked, tbl[i].e_err, tbl[i].e_cnt, tbl[i].e_phase,
                  $sformatf("vec%0d", i));
        end

        // Valid toggling while locked, then reset with a corrupt sample present.
        reset_and_lock("tog");
        p = 3'd0;
        for (int i = 0; i < 8; i++) begin
            p = p + 3'd1;
            apply(0, 1, seq_ref[p], 0, 1, 0, 8'd0, p, "tog_valid");
            apply(0, 0, 3'd7, 0, 1, 0, 8'd0, p, "tog_idle");
        end
        apply(1, 1, 3'd7, 0, 0, 0, 8'd0, 3'd0, "rst_locked");
        apply(0, 1, 3'd1, 0, 0, 0, 8'd0, 3'd1, "reacq");

        // Saturation: 260 errors interleaved with matches so lock holds.
        reset_and_lock("sat");
        p = 3'd0;
        n = 0;
        for (int i = 0; i < 260; i++) begin
            n++;
            p = p + 3'd1;
            ecnt = (n > 255) ? 8'd255 : 8'(n);
            apply(0, 1, 3'd0, 0, 1, 1, ecnt, p, "sat_err");
            p = p + 3'd1;
            apply(0, 1, seq_ref[p], 0, 1, 0, ecnt, p, "sat_ok");
        end
        // Clear with a simultaneous error: clear wins, err still pulses.
        p = p + 3'd1;
        apply(0, 1, 3'd0, 1, 1, 1, 8'd0, p, "clr_vs_err");
        p = p + 3'd1;
        apply(0, 1, seq_ref[p], 0, 1, 0, 8'd0, p, "after_clr");

        if (sb_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
